spi_flash_rd: RTL and testbench

Parametrised multi-lane SPI flash read master. Takes one command descriptor per `start` and drives a serial NOR flash through the command, optional address, optional dummy and N-byte data phases. It supports x1, x2 and x4 lane modes and a programmable SCLK divider. It sits between the boot/loader logic and the flash pins, and succeeds the fixed x1 single-byte reader.

---
 rtl/spi_flash_pkg.sv | 36 +++
 rtl/spi_sclk_gen.sv | 46 ++++
 rtl/spi_flash_rd.sv | 216 +++++++++++++++++++++
 tb/tb_spi_flash_rd.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_pkg
// Description : Shared FSM encoding, lane-mode codes and lane-width helper for
//               the SPI flash read master. x4 enabled by SPI_FLASH_QUAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_flash_pkg;

    localparam logic [6:0] ST_IDLE     = 7'b000_0001;
    localparam logic [6:0] ST_CS_SETUP = 7'b000_0010;
    localparam logic [6:0] ST_CMD      = 7'b000_0100;
    localparam logic [6:0] ST_ADDR     = 7'b000_1000;
    localparam logic [6:0] ST_DUMMY    = 7'b001_0000;
    localparam logic [6:0] ST_DATA     = 7'b010_0000;
    localparam logic [6:0] ST_CS_HOLD  = 7'b100_0000;

    localparam logic [1:0] MODE_X1 = 2'd0;
    localparam logic [1:0] MODE_X2 = 2'd1;
    localparam logic [1:0] MODE_X4 = 2'd2;

    // Reserved codes (and x4 when the quad lanes are absent) collapse to x1.
    function automatic logic [2:0] bits_per_sclk(input logic [1:0] mode);
        logic [2:0] w_bits;
        case (mode)
            MODE_X2: w_bits = 3'd2;
`ifdef SPI_FLASH_QUAD_EN
            MODE_X4: w_bits = 3'd4;
`endif
            default: w_bits = 3'd1;
        endcase
        return w_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_gen
// Description : SCLK divider; toggles sclk every CLK_DIV/2 enabled cycles and
//               flags the cycle before each edge. (SPI_FLASH_QUAD_EN-neutral)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_stb,
    output logic o_fall_stb
);

    localparam int              c_half = CLK_DIV / 2;
    localparam int              c_cw   = (c_half > 1) ? $clog2(c_half) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_half - 1);

    logic [c_cw-1:0] r_cnt;
    logic            r_sclk;
    logic            w_tick;

    // Strobes lead the sclk edge by one cycle so the FSM moves with it.
    assign w_tick     = i_en && (r_cnt == c_last);
    assign o_rise_stb = w_tick && !r_sclk;
    assign o_fall_stb = w_tick && r_sclk;
    assign o_sclk     = r_sclk;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_flash_rd.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_rd
// Description : Multi-lane (x1/x2/x4) SPI NOR read master: CMD/ADDR/DUMMY/DATA.
//               Define SPI_FLASH_QUAD_EN to build the x4 lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_rd
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int ADDR_BYTES = 3,
    parameter int LEN_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              cmd,
    input  logic [8*ADDR_BYTES-1:0] addr,
    input  logic                    addr_en,
    input  logic [3:0]              dummy_cyc,
    input  logic [1:0]              mode,
    input  logic [LEN_W-1:0]        len,
    output logic                    busy,
    output logic [7:0]              rd_data,
    output logic                    rd_valid,
    output logic                    done,
    output logic                    sclk,
    output logic                    cs_n,
    output logic [3:0]              io_out,
    output logic [3:0]              io_oe,
    input  logic [3:0]              io_in
);

    logic [6:0]              r_state;
    logic [7:0]              r_bits;
    logic [LEN_W-1:0]        r_len;
    logic [31:0]             r_tx;
    logic [7:0]              r_rx;
    logic [8*ADDR_BYTES-1:0] r_addr;
    logic                    r_addr_en;
    logic [3:0]              r_dummy;
    logic [2:0]              r_w;
    logic [7:0]              r_rd_data;
    logic                    r_rd_valid;
    logic                    r_done;

    logic        w_en, w_rise, w_fall, w_accept;
    logic [6:0]  w_nxt;
    logic [7:0]  w_nxt_bits, w_addr_rises, w_byte_rises;
    logic [31:0] w_addr_al, w_tx_shift;
    logic [7:0]  w_rx_nxt;
    logic [3:0]  w_oe, w_out;

    assign w_en = |(r_state & (ST_CS_SETUP | ST_CMD | ST_ADDR | ST_DUMMY | ST_DATA));
    // The done cycle already shows busy=0, but a new request waits one more cycle.
    assign w_accept = start && (r_state == ST_IDLE) && !r_done;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_en),
        .o_sclk     (sclk),
        .o_rise_stb (w_rise),
        .o_fall_stb (w_fall)
    );

    assign w_addr_al  = 32'(r_addr) << (32 - 8 * ADDR_BYTES);
    assign w_tx_shift = (r_state == ST_ADDR) ? (r_tx << r_w) : (r_tx << 1);

    always_comb begin
        w_addr_rises = 8'(8 * ADDR_BYTES);
        w_byte_rises = 8'd8;
        w_rx_nxt     = {r_rx[6:0], io_in[1]};
        case (r_w)
            3'd2: begin
                w_addr_rises = 8'(4 * ADDR_BYTES);
                w_byte_rises = 8'd4;
                w_rx_nxt     = {r_rx[5:0], io_in[1:0]};
            end
`ifdef SPI_FLASH_QUAD_EN
            3'd4: begin
                w_addr_rises = 8'(2 * ADDR_BYTES);
                w_byte_rises = 8'd2;
                w_rx_nxt     = {r_rx[3:0], io_in[3:0]};
            end
`endif
            default: ;
        endcase
    end

    // Next enabled phase after the current one; disabled phases fall through.
    always_comb begin
        w_nxt      = ST_CS_HOLD;
        w_nxt_bits = 8'(CLK_DIV - 1);
        if (r_state == ST_CMD && r_addr_en) begin
            w_nxt      = ST_ADDR;
            w_nxt_bits = w_addr_rises;
        end else if ((r_state == ST_CMD || r_state == ST_ADDR) && r_dummy != 4'd0) begin
            w_nxt      = ST_DUMMY;
            w_nxt_bits = {4'd0, r_dummy};
        end else if (r_state != ST_DATA && r_len != '0) begin
            w_nxt      = ST_DATA;
            w_nxt_bits = w_byte_rises;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bits     <= 8'd0;
            r_len      <= '0;
            r_tx       <= 32'd0;
            r_rx       <= 8'd0;
            r_addr     <= '0;
            r_addr_en  <= 1'b0;
            r_dummy    <= 4'd0;
            r_w        <= 3'd1;
            r_rd_data  <= 8'd0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_CS_SETUP;
                        r_tx      <= {cmd, 24'd0};
                        r_bits    <= 8'd8;
                        r_addr    <= addr;
                        r_addr_en <= addr_en;
                        r_dummy   <= dummy_cyc;
                        r_w       <= bits_per_sclk(mode);
                        r_len     <= len;
                    end
                end
                ST_CS_HOLD: begin
                    if (r_bits == 8'd0) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_bits <= r_bits - 8'd1;
                    end
                end
                default: begin
                    // r_bits counts rising edges still owed by the current phase/byte.
                    if (w_rise) begin
                        r_bits <= r_bits - 8'd1;
                        if (r_state == ST_CS_SETUP) begin
                            r_state <= ST_CMD;
                        end
                        if (r_state == ST_DATA) begin
                            r_rx <= w_rx_nxt;
                            if (r_bits == 8'd1) begin
                                r_rd_data  <= w_rx_nxt;
                                r_rd_valid <= 1'b1;
                                r_len      <= r_len - 1'b1;
                            end
                        end
                    end
                    if (w_fall) begin
                        if (r_bits != 8'd0) begin
                            r_tx <= w_tx_shift;
                        end else if (r_state == ST_DATA && r_len != '0) begin
                            r_bits <= w_byte_rises;
                        end else begin
                            r_state <= w_nxt;
                            r_bits  <= w_nxt_bits;
                            if (w_nxt == ST_ADDR) begin
                                r_tx <= w_addr_al;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_oe  = 4'b0000;
        w_out = {3'b000, r_tx[31]};
        if (r_state == ST_CS_SETUP || r_state == ST_CMD) begin
            w_oe = 4'b0001;
        end else if (r_state == ST_ADDR) begin
            case (r_w)
                3'd2: begin
                    w_oe  = 4'b0011;
                    w_out = {2'b00, r_tx[31:30]};
                end
`ifdef SPI_FLASH_QUAD_EN
                3'd4: begin
                    w_oe  = 4'b1111;
                    w_out = r_tx[31:28];
                end
`endif
                default: w_oe = 4'b0001;
            endcase
        end
    end

`ifndef SPI_FLASH_QUAD_EN
    logic w_unused;
    assign w_unused = ^io_in[3:2];
`endif

    assign io_oe    = w_oe;
    assign io_out   = w_out & w_oe;
    assign cs_n     = ~w_en;
    assign busy     = (r_state != ST_IDLE);
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_rd.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_rd
// Description : Directed table-driven bench for spi_flash_rd with a flash model.
//               Expectations follow SPI_FLASH_QUAD_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_rd;

    localparam int CLK_DIV = 4;
    localparam int H       = CLK_DIV / 2;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic        ae;
        logic [3:0]  dummy;
        logic [1:0]  mode;
        logic [7:0]  len;
        logic [31:0] resp;
        int          exp_rises;
        logic [3:0]  exp_oe;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cmd = 8'd0;
    logic [23:0] addr = 24'd0;
    logic        addr_en = 1'b0;
    logic [3:0]  dummy_cyc = 4'd0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  len = 8'd0;
    logic        busy, rd_valid, done, sclk, cs_n;
    logic [7:0]  rd_data;
    logic [3:0]  io_out, io_oe;
    logic [3:0]  io_in = 4'd0;

    spi_flash_rd #(.CLK_DIV(CLK_DIV), .ADDR_BYTES(3), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr(addr),
        .addr_en(addr_en), .dummy_cyc(dummy_cyc), .mode(mode), .len(len),
        .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
        .sclk(sclk), .cs_n(cs_n), .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
    );

    always #5 clk = ~clk;

    // Flash model parameters, written by the stimulus tasks only.
    int          m_w = 1, m_d0 = 8, m_arises = 24, m_len = 0;
    logic        m_ae = 1'b0;
    logic [31:0] m_resp = 32'd0;
    logic        clr = 1'b0;

    // Monitor state, written by the monitor only.
    int          n_cyc = 0, rise_cnt = 0, vcnt = 0, dcnt = 0, hi_viol = 0;
    int          first_rise_cyc = 0, cs_rise_cyc = 0, done_cyc = 0;
    logic        prev_sclk = 1'b0, prev_cs = 1'b1;
    logic [7:0]  cap_cmd = 8'd0;
    logic [31:0] cap_addr = 32'd0;
    logic [3:0]  oe_or = 4'd0;
    logic [7:0]  rx [8];

    int n_pass = 0, n_total = 0, cur = 0, t0 = 0;
    vec_t vecs [6];

    function automatic int lanes(input logic [1:0] md);
        if (md == 2'd1) return 2;
`ifdef SPI_FLASH_QUAD_EN
        if (md == 2'd2) return 4;
`endif
        return 1;
    endfunction

    // io_in value that the flash presents ahead of rising edge number k.
    function automatic logic [3:0] model_io(input int k);
        int         j, p, b, s;
        logic [7:0] byt, sh;
        logic [3:0] bits;
        if (k < m_d0) return 4'd0;
        j = k - m_d0;
        p = 8 / m_w;
        b = j / p;
        s = j % p;
        if (b >= m_len) return 4'd0;
        byt  = 8'((m_resp >> (24 - 8 * b)) & 32'hFF);
        sh   = byt << (s * m_w);
        bits = 4'(sh >> (8 - m_w));
        if (m_w == 1) return {2'b11, bits[0], ~bits[0]};
        if (m_w == 2) return {2'b11, bits[1:0]};
        return bits;
    endfunction

    always @(negedge clk) begin
        n_cyc = n_cyc + 1;
        if (clr) begin
            rise_cnt = 0; vcnt = 0; dcnt = 0; hi_viol = 0;
            first_rise_cyc = 0; cs_rise_cyc = 0; done_cyc = 0;
            cap_cmd = 8'd0; cap_addr = 32'd0; oe_or = 4'd0;
        end else begin
            if (sclk && !prev_sclk) begin
                if (rise_cnt < 8)
                    cap_cmd = {cap_cmd[6:0], io_out[0]};
                else if (m_ae && rise_cnt < 8 + m_arises)
                    cap_addr = (cap_addr << m_w) | 32'(io_out & 4'((1 << m_w) - 1));
                if (rise_cnt == 0) first_rise_cyc = n_cyc;
                rise_cnt = rise_cnt + 1;
            end
            if (cs_n && !prev_cs) cs_rise_cyc = n_cyc;
            if (rd_valid) begin
                if (vcnt < 8) rx[vcnt] = rd_data;
                vcnt = vcnt + 1;
            end
            if (done) begin
                dcnt = dcnt + 1;
                done_cyc = n_cyc;
            end
            oe_or = oe_or | io_oe;
            if (m_w != 4 && (io_oe[3:2] != 2'b00 || io_out[3:2] != 2'b00))
                hi_viol = hi_viol + 1;
        end
        prev_sclk = sclk;
        prev_cs   = cs_n;
        io_in     = model_io(rise_cnt);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s (vec %0d): got %0h, expected %0h", name, cur, act, exp);
    endtask

    task automatic start_txn(input int i);
        cur      = i;
        m_w      = lanes(vecs[i].mode);
        m_ae     = vecs[i].ae;
        m_len    = int'(vecs[i].len);
        m_resp   = vecs[i].resp;
        m_arises = 24 / m_w;
        m_d0     = 8 + (vecs[i].ae ? m_arises : 0) + int'(vecs[i].dummy);
        clr = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        clr = 1'b0;
        cmd = vecs[i].cmd; addr = vecs[i].addr; addr_en = vecs[i].ae;
        dummy_cyc = vecs[i].dummy; mode = vecs[i].mode; len = vecs[i].len;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = n_cyc;
        check("busy_after_start", busy, 1);
        check("cs_n_after_start", cs_n, 0);
        check("sclk_in_setup", sclk, 0);
    endtask

    task automatic finish_txn(input int i);
        logic got = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", got, 1);
        check("busy_at_done", busy, 0);
        check("cs_n_at_done", cs_n, 1);
        repeat (3) @(posedge clk);
        #1;
        check("first_rise_latency", first_rise_cyc - t0, H + 1);
        check("rise_count", rise_cnt, vecs[i].exp_rises);
        check("done_count", dcnt, 1);
        check("valid_count", vcnt, int'(vecs[i].len));
        for (int b = 0; b < int'(vecs[i].len) && b < 4; b++)
            check("rd_data", rx[b], (vecs[i].resp >> (24 - 8 * b)) & 32'hFF);
        check("cmd_shifted_out", cap_cmd, vecs[i].cmd);
        if (vecs[i].ae) check("addr_shifted_out", cap_addr[23:0], vecs[i].addr);
        check("io_oe_seen", oe_or, vecs[i].exp_oe);
        check("upper_lanes_idle", hi_viol, 0);
        check("cs_high_to_done", done_cyc - cs_rise_cyc, CLK_DIV);
    endtask

    initial begin
        vecs[0] = '{8'h03, 24'h123456, 1'b1, 4'd0, 2'd0, 8'd2, 32'hA53C_0000, 48, 4'b0001};
`ifdef SPI_FLASH_QUAD_EN
        vecs[1] = '{8'hEB, 24'h000100, 1'b1, 4'd6, 2'd2, 8'd4, 32'h0102_0304, 28, 4'b1111};
`else
        vecs[1] = '{8'hEB, 24'h000100, 1'b1, 4'd6, 2'd2, 8'd4, 32'h0102_0304, 70, 4'b0001};
`endif
        vecs[2] = '{8'h9F, 24'h000000, 1'b0, 4'd0, 2'd0, 8'd3, 32'hEF40_1800, 32, 4'b0001};
        vecs[3] = '{8'h06, 24'h000000, 1'b0, 4'd0, 2'd0, 8'd0, 32'h0000_0000, 8,  4'b0001};
        vecs[4] = '{8'h3B, 24'hABCDEF, 1'b1, 4'd8, 2'd1, 8'd2, 32'h5AC3_0000, 36, 4'b0011};
        vecs[5] = '{8'h0B, 24'h000010, 1'b1, 4'd8, 2'd3, 8'd1, 32'h7E00_0000, 48, 4'b0001};

        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", sclk, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_io_out", io_out, 0);
        check("rst_io_oe", io_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            start_txn(i);
            finish_txn(i);
        end

        // Second start while busy must be ignored entirely.
        start_txn(3);
        repeat (3) @(posedge clk);
        #1;
        cmd = 8'h9F; addr_en = 1'b0; len = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_txn(3);
        repeat (20) @(posedge clk);
        #1;
        check("ignored_start_busy", busy, 0);
        check("ignored_start_done", dcnt, 1);

        // Reset in the middle of the second data byte.
        start_txn(0);
        begin
            logic got = 1'b0;
            for (int c = 0; c < 2000; c++) begin
                @(posedge clk); #1;
                if (vcnt >= 1) begin
                    got = 1'b1;
                    break;
                end
            end
            check("reset_reach_byte2", got, 1);
        end
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_cs_n", cs_n, 1);
        check("midrst_sclk", sclk, 0);
        check("midrst_io_oe", io_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd_valid", rd_valid, 0);
        repeat (60) @(posedge clk);
        #1;
        check("midrst_no_done", dcnt, 0);
        check("midrst_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
